cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL provide parameter RESERVED_CONDEX, default 1'b0, giving the CondEx value for Cond=4'b1111.
REQ-002 SHALL provide port clk  input  1  single rising-edge system clock.
REQ-003 SHALL provide port reset  input  1  asynchronous active-low reset; assertion (0) clears state immediately; deassertion is released synchronously by the system.
REQ-004 SHALL provide port Cond  input  4  instruction condition field, bits [31:28].
REQ-005 SHALL provide port ALUFlags  input  4  ALU result flags {N,Z,C,V}.
REQ-006 SHALL provide port FlagW  input  2  flag write request: [1] selects N,Z and [0] selects C,V.
REQ-007 SHALL provide port PCS  input  1  instruction writes PC (branch or Rd=R15).
REQ-008 SHALL provide port NextPC  input  1  unconditional PC increment request from the main FSM.
REQ-009 SHALL provide port RegW  input  1  register-write request from the main FSM.
REQ-010 SHALL provide port MemW  input  1  memory-write request from the main FSM.
REQ-011 SHALL provide port PCWrite  output  1  gated PC write enable.
REQ-012 SHALL provide port RegWrite  output  1  gated register-file write enable.
REQ-013 SHALL provide port MemWrite  output  1  gated memory write enable.
REQ-014 SHALL provide port Flags  output  4  architectural {N,Z,C,V} register contents.
REQ-015 SHALL provide port CondExD  output  1  registered condition-pass bit.

Function
REQ-016 SHALL compute CondEx combinationally from Cond and the registered Flags: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 RESERVED_CONDEX.
REQ-017 SHALL register CondEx into CondExD on every rising clk edge, with no enable.
REQ-018 SHALL form FlagWrite[1:0] = FlagW & {2{CondEx}}, using the unregistered CondEx.
REQ-019 SHALL load Flags[3:2] from ALUFlags[3:2] on the edge where FlagWrite[1]=1, and hold them otherwise.
REQ-020 SHALL load Flags[1:0] from ALUFlags[1:0] on the edge where FlagWrite[0]=1, and hold them otherwise; the two halves are independent.
REQ-021 SHALL drive PCWrite = (PCS & CondExD) | NextPC, so NextPC is never gated by the condition.
REQ-022 SHALL drive RegWrite = RegW & CondExD and MemWrite = MemW & CondExD.
REQ-023 SHALL evaluate a condition against Flags as they stood before the current edge; a flag update and a CondEx evaluation in the same cycle use the old flags, and the new value is visible the following cycle.
REQ-024 SHALL add no combinational path from ALUFlags to any output and none from Cond to PCWrite, RegWrite or MemWrite.
REQ-025 SHALL give one cycle of latency from Cond/Flags to CondExD and to the gated enables.

Reset
REQ-026 SHALL, while reset=0, force Flags=4'b0000 and CondExD=0 asynchronously.
REQ-027 SHALL, during reset, hold PCWrite=NextPC, RegWrite=0 and MemWrite=0.
REQ-028 SHALL, on a reset asserted mid-instruction, discard the pending CondExD, so the write enables of that instruction are suppressed.
REQ-029 SHALL make the first edge after deassertion behave as a normal cycle.

Structure
REQ-030 SHALL place the shared package cond constants (EQ..AL, NV=4'b1111) and flag bit indices (N=3, Z=2, C=1, V=0) in the shared package used by the control path.
REQ-031 SHALL implement REQ-016 as a purely combinational sub-module named condcheck; flag and CondExD registers stay in cond_unit.

Verification
REQ-032 SHALL cover reset: with reset=0 and NextPC=1, expect Flags=0000, CondExD=0, PCWrite=1 and RegWrite=0 immediately, before any clk edge.
REQ-033 SHALL cover CMP then BEQ: with Cond=1110, FlagW=11, ALUFlags=0100, expect Flags=0100 after one edge; then with Cond=0000, PCS=1, expect PCWrite=1 on the next cycle.
REQ-034 SHALL cover a failed condition: with Flags=0000, Cond=0000, RegW=1 and MemW=1, expect RegWrite=0, MemWrite=0 and no flag change even with FlagW=11.
REQ-035 SHALL cover a partial flag write: with Flags=1111, FlagW=10, ALUFlags=0000 and Cond=AL, expect Flags=0011.
REQ-036 SHALL cover signed conditions: with Flags=1001 (N=1,V=1), expect GE pass, LT fail, GT pass and LE fail; with Flags=1000, expect GE fail and LT pass.
REQ-037 SHALL cover reset mid-op: with CondExD=1 and RegW=1, pulse reset low for half a cycle; expect RegWrite=0 immediately and Flags=0000.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// Shared control-path definitions: ARM condition-field encodings and the bit
// positions of the {N,Z,C,V} flags inside the 4-bit flag vector.
package cond_unit_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_condcheck.sv
// Purely combinational condition evaluator: decides whether an instruction with
// condition field i_cond executes, given the architectural flags i_flags.
module condcheck
  import cond_unit_pkg::*;
#(
  parameter logic RESERVED_CONDEX = 1'b0
) (
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condEx
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign w_n  = i_flags[FLAG_N];
  assign w_z  = i_flags[FLAG_Z];
  assign w_c  = i_flags[FLAG_C];
  assign w_v  = i_flags[FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_condEx = 1'b0;
    case (cond_e'(i_cond))
      EQ:      o_condEx = w_z;
      NE:      o_condEx = ~w_z;
      CS:      o_condEx = w_c;
      CC:      o_condEx = ~w_c;
      MI:      o_condEx = w_n;
      PL:      o_condEx = ~w_n;
      VS:      o_condEx = w_v;
      VC:      o_condEx = ~w_v;
      HI:      o_condEx = w_c & ~w_z;
      LS:      o_condEx = ~w_c | w_z;
      GE:      o_condEx = w_ge;
      LT:      o_condEx = ~w_ge;
      GT:      o_condEx = ~w_z & w_ge;
      LE:      o_condEx = w_z | ~w_ge;
      AL:      o_condEx = 1'b1;
      default: o_condEx = RESERVED_CONDEX;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural flags, registers the
// condition-pass bit and gates the main FSM's write requests with it.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter logic RESERVED_CONDEX = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondExD
);

  logic [3:0] r_flags;
  logic       r_condExD;
  logic       w_condEx;
  logic [1:0] w_flagWrite;

  condcheck #(
    .RESERVED_CONDEX(RESERVED_CONDEX)
  ) u_condcheck (
    .i_cond   (Cond),
    .i_flags  (r_flags),
    .o_condEx (w_condEx)
  );

  // Flag writes are squashed by the same-cycle condition, evaluated on old flags.
  assign w_flagWrite = FlagW & {2{w_condEx}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags   <= 4'b0000;
      r_condExD <= 1'b0;
    end else begin
      if (w_flagWrite[1]) begin
        r_flags[FLAG_N] <= ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (w_flagWrite[0]) begin
        r_flags[FLAG_C] <= ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
      r_condExD <= w_condEx;
    end
  end

  // NextPC is the fetch increment and must never be blocked by a failed condition.
  assign PCWrite  = (PCS & r_condExD) | NextPC;
  assign RegWrite = RegW & r_condExD;
  assign MemWrite = MemW & r_condExD;
  assign Flags    = r_flags;
  assign CondExD  = r_condExD;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a flag/condition model checked every cycle
// plus hand-computed directed expectations for the key scenarios.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondExD;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn    = 1'b0;

  logic [3:0] mFlags   = 4'b0000;
  logic       mCondExD = 1'b0;

  cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondExD  (CondExD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural meaning of each condition code over flags {N,Z,C,V}.
  function automatic bit condPasses(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, signedGe;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    signedGe = (n == v);
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return signedGe;
      4'd11:   return !signedGe;
      4'd12:   return !z && signedGe;
      4'd13:   return z || !signedGe;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: flags and pass bit as the architecture defines them.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mFlags   = 4'b0000;
      mCondExD = 1'b0;
    end else begin
      bit pass;
      pass = condPasses(Cond, mFlags);
      if (pass && FlagW[1]) mFlags[3:2] = ALUFlags[3:2];
      if (pass && FlagW[0]) mFlags[1:0] = ALUFlags[1:0];
      mCondExD = pass;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model Flags",    Flags,              mFlags);
      checkOutput("model CondExD",  {3'b0, CondExD},    {3'b0, mCondExD});
      checkOutput("model PCWrite",  {3'b0, PCWrite},    {3'b0, NextPC | (PCS & mCondExD)});
      checkOutput("model RegWrite", {3'b0, RegWrite},   {3'b0, RegW & mCondExD});
      checkOutput("model MemWrite", {3'b0, MemWrite},   {3'b0, MemW & mCondExD});
    end
  end

  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] alu,
                               input logic [1:0] fw, input logic pcs,
                               input logic nextPc, input logic regW, input logic memW);
    Cond     = c;
    ALUFlags = alu;
    FlagW    = fw;
    PCS      = pcs;
    NextPC   = nextPc;
    RegW     = regW;
    MemW     = memW;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic loadFlags(input logic [3:0] f);
    applyStimulus(4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
  endtask

  initial begin
    logic [3:0] flagPatterns [4];
    flagPatterns[0] = 4'b0000;
    flagPatterns[1] = 4'b0110;
    flagPatterns[2] = 4'b1011;
    flagPatterns[3] = 4'b0101;

    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("reset Flags",    Flags,            4'b0000);
    checkOutput("reset CondExD",  {3'b0, CondExD},  4'd0);
    checkOutput("reset PCWrite",  {3'b0, PCWrite},  4'd1);
    checkOutput("reset RegWrite", {3'b0, RegWrite}, 4'd0);
    checkOutput("reset MemWrite", {3'b0, MemWrite}, 4'd0);

    stepCycle();
    reset   = 1'b1;
    checkEn = 1'b1;

    // CMP setting Z, then BEQ.
    applyStimulus(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("cmp Flags", Flags, 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("beq PCWrite", {3'b0, PCWrite}, 4'd1);

    // Failed EQ suppresses writes and flag update.
    loadFlags(4'b0000);
    applyStimulus(4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("fail RegWrite", {3'b0, RegWrite}, 4'd0);
    checkOutput("fail MemWrite", {3'b0, MemWrite}, 4'd0);
    checkOutput("fail Flags",    Flags,            4'b0000);

    // Only N,Z written.
    loadFlags(4'b1111);
    applyStimulus(4'b1110, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("partial Flags", Flags, 4'b0011);

    // Signed conditions.
    loadFlags(4'b1001);
    applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("GE n1v1", {3'b0, CondExD}, 4'd1);
    applyStimulus(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("LT n1v1", {3'b0, CondExD}, 4'd0);
    applyStimulus(4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("GT n1v1", {3'b0, CondExD}, 4'd1);
    applyStimulus(4'b1101, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("LE n1v1", {3'b0, CondExD}, 4'd0);
    loadFlags(4'b1000);
    applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("GE n1v0", {3'b0, CondExD}, 4'd0);
    applyStimulus(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("LT n1v0", {3'b0, CondExD}, 4'd1);

    // Same-edge update uses old flags; new flags seen next cycle.
    applyStimulus(4'b1011, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("old-flag LT pass", {3'b0, CondExD}, 4'd1);
    checkOutput("old-flag Flags",   Flags,           4'b0000);
    applyStimulus(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); stepCycle();
    checkOutput("new-flag LT fail", {3'b0, CondExD}, 4'd0);

    // Reserved code and NextPC bypass.
    applyStimulus(4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0); stepCycle();
    checkOutput("NV CondExD", {3'b0, CondExD}, 4'd0);
    checkOutput("NV PCWrite", {3'b0, PCWrite}, 4'd1);
    checkOutput("NV Flags",   Flags,           4'b0000);

    // Sweep every condition code over several flag patterns.
    for (int p = 0; p < 4; p++) begin
      loadFlags(flagPatterns[p]);
      for (int c = 0; c < 16; c++) begin
        applyStimulus(4'(c), 4'(c ^ 5), 2'(c), 1'b1, 1'b0, 1'b1, 1'b1);
        stepCycle();
      end
    end

    // Reset pulse mid-instruction.
    applyStimulus(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("pre-reset RegWrite", {3'b0, RegWrite}, 4'd1);
    checkOutput("pre-reset Flags",    Flags,            4'b0110);
    reset = 1'b0;
    #1;
    checkOutput("midreset RegWrite", {3'b0, RegWrite}, 4'd0);
    checkOutput("midreset Flags",    Flags,            4'b0000);
    checkOutput("midreset CondExD",  {3'b0, CondExD},  4'd0);
    #4;
    reset = 1'b1;
    applyStimulus(4'b0001, 4'b1010, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("post-reset CondExD", {3'b0, CondExD}, 4'd1);
    checkOutput("post-reset Flags",   Flags,           4'b0010);
    applyStimulus(4'b0010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
